// File: rtl/branch_redirect_ctrl.sv
// Decode-stage branch resolver: selects immediate extension, holds ID until the operands
// it needs are forwardable, and sends a registered PC redirect with an IF flush.
module branch_redirect_ctrl #(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [31:0]      id_pc4,
    input  logic [31:0]      simm,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             rs_hazard,
    input  logic             rt_hazard,
    output logic             ext_op,
    output logic             id_stall,
    output logic             if_flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic             hazard_timeout,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_OPND = 2'd1,
        REDIRECT  = 2'd2
    } state_t;

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    // Redirect handshake: redirect_pc is offered while redirect_valid is high and must not
    // change until the cycle in which redirect_valid & redirect_ready are both high at the
    // clock edge; redirect_ready has no meaning while redirect_valid is low.

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        is_br;
    logic        needs_rt;
    logic        hazard;
    logic        active;
    logic        evaluate;
    logic        taken;
    logic        rs_eq_rt;
    logic        rs_zero;
    logic [31:0] target;

    assign state_dbg = state;

    // andi/ori/xori/lui (0x0C..0x0F) are the only zero-extending opcodes.
    always_comb begin
        ext_op = (id_opcode[5:2] != 4'b0011);
    end

    always_comb begin
        is_br    = id_valid && (id_opcode[5:2] == 4'b0001);
        needs_rt = ~id_opcode[1];
        hazard   = rs_hazard | (needs_rt & rt_hazard);
        active   = (state == IDLE) || (state == WAIT_OPND);
        id_stall = active & is_br & hazard;
        evaluate = active & is_br & ~hazard;
        rs_eq_rt = (rs_val == rt_val);
        rs_zero  = (rs_val == 32'd0);
        target   = id_pc4 + simm;
        taken    = 1'b0;
        case (id_opcode[1:0])
            2'd0:    taken = rs_eq_rt;
            2'd1:    taken = ~rs_eq_rt;
            2'd2:    taken = rs_val[31] | rs_zero;
            default: taken = ~rs_val[31] & ~rs_zero;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else if (evaluate) begin
            if (branch_cnt != '1) branch_cnt <= branch_cnt + 1'b1;
            if (taken && (taken_cnt != '1)) taken_cnt <= taken_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= 8'd0;
            hazard_timeout <= 1'b0;
            redirect_valid <= 1'b0;
            if_flush       <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            case (state)
                IDLE, WAIT_OPND: begin
                    if (!is_br) begin
                        // a squashed or replaced instruction abandons the wait silently
                        state <= IDLE;
                    end else if (hazard) begin
                        state <= WAIT_OPND;
                        if (state == IDLE) begin
                            wait_cnt <= 8'd1;
                            if (MAX_W == 8'd1) hazard_timeout <= 1'b1;
                        end else if (wait_cnt != MAX_W) begin
                            wait_cnt <= wait_cnt + 8'd1;
                            if (8'(wait_cnt + 8'd1) == MAX_W) hazard_timeout <= 1'b1;
                        end
                    end else if (taken) begin
                        state          <= REDIRECT;
                        redirect_valid <= 1'b1;
                        if_flush       <= 1'b1;
                        redirect_pc    <= target;
                    end else begin
                        state <= IDLE;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                        if_flush       <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b0;
                    if_flush       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Decode-stage controller for conditional branches in the 5-stage pipeline. Configures the immediate extender by driving its sign/zero-extend select, takes back the shifted immediate, and resolves beq/bne/blez/bgtz. It holds decode while branch operands are still in flight and issues a registered PC redirect with an IF flush through a valid/ready handshake to the PC unit. It also keeps branch/taken statistics.

Parameters:
MAX_WAIT, 8, operand-wait cycles before the sticky hazard_timeout flag sets (1..255)
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID stage holds a valid instruction
id_opcode  in  6  instruction[31:26]
id_pc4  in  32  PC+4 of the ID instruction
simm  in  32  shifted extended immediate from the immediate extender
rs_val  in  32  forwarded rs operand
rt_val  in  32  forwarded rt operand
rs_hazard  in  1  rs not yet forwardable
rt_hazard  in  1  rt not yet forwardable
ext_op  out  1  extend select to the immediate extender (1 = sign)
id_stall  out  1  hold PC and IF/ID
if_flush  out  1  load NOP into IF/ID
redirect_valid  out  1  redirect_pc is valid
redirect_pc  out  32  branch target
redirect_ready  in  1  PC unit accepts the redirect
branch_cnt  out  CNT_W  branches resolved, saturating
taken_cnt  out  CNT_W  branches taken, saturating
hazard_timeout  out  1  sticky: operand wait reached MAX_WAIT

Behaviour:
- ext_op is combinational from id_opcode.
  - 0 for andi 0x0C, ori 0x0D, xori 0x0E, lui 0x0F.
  - 1 for every other opcode, including branches 0x04–0x07, addi/addiu, slti/sltiu, lw, sw.
- A branch is id_valid & id_opcode in {0x04 beq, 0x05 bne, 0x06 blez, 0x07 bgtz}.
- Operands needed:
  - beq/bne need rs and rt.
  - blez/bgtz need rs only; rt_hazard is ignored for them.
- Conditions:
  - beq: rs==rt.
  - bne: rs!=rt.
  - blez: rs signed <= 0.
  - bgtz: rs signed > 0.
- Target = id_pc4 + simm, 32-bit modular; wraps with no error.
- FSM states: IDLE, WAIT_OPND, REDIRECT.
- IDLE:
  - Outputs id_stall=0, if_flush=0, redirect_valid=0.
  - Branch with a needed hazard: id_stall=1 combinationally in that cycle; next state WAIT_OPND; wait_cnt=1.
  - Branch with no needed hazard: evaluate this cycle (cycle N).
    - branch_cnt increments.
    - If taken: taken_cnt increments, redirect_pc <= target, next state REDIRECT.
    - If not taken: stay IDLE, no stall.
  - Non-branch: no action.
- WAIT_OPND:
  - id_stall=1 while any needed hazard remains; wait_cnt increments, saturating at MAX_WAIT.
  - When wait_cnt==MAX_WAIT, hazard_timeout sets. It clears only on reset.
  - When the needed hazards clear: id_stall=0 that cycle and evaluate exactly as in IDLE. Next state is REDIRECT if taken, otherwise IDLE.
  - If id_valid drops (external squash): return to IDLE with no evaluation and no counter change.
- REDIRECT:
  - redirect_valid=1 and if_flush=1 every cycle in this state.
  - id_stall=0. id_valid and id_opcode are ignored; no new branch is evaluated.
  - redirect_pc is held stable until the handshake completes.
  - Handshake completes on redirect_valid & redirect_ready; next state IDLE.
  - redirect_ready is ignored when redirect_valid=0.
- Latency: taken branch evaluated in cycle N gives redirect_valid from N+1. A ready-high PC unit accepts in N+1 and the FSM is back in IDLE at N+2.
- Counters saturate at all-ones. Both counters increment in the same cycle for a taken branch.
- Reset (any state, including mid-REDIRECT or mid-WAIT_OPND):
  - state IDLE.
  - redirect_valid, if_flush, id_stall = 0.
  - redirect_pc = 0.
  - branch_cnt, taken_cnt, wait_cnt = 0.
  - hazard_timeout = 0.
  - A pending redirect is dropped.

Test Plan:
- beq taken, no hazard: opcode 0x04, rs=rt=5, pc4=0x00400004, simm=0x0000000C -> cycle N+1 redirect_valid=1, redirect_pc=0x00400010, if_flush=1; ready=1 -> IDLE at N+2; branch_cnt=1, taken_cnt=1.
- Negative offset bne: rs=1, rt=2, pc4=0x00400020, simm=0xFFFFFFF8 -> redirect_pc=0x00400018. pc4=0x00000004 with the same simm -> redirect_pc=0xFFFFFFFC (wrap).
- Load-use stall: beq, rt_hazard=1 for 3 cycles, then 0 with rs!=rt -> id_stall=1 for exactly 3 cycles, no redirect, branch_cnt+1, taken_cnt unchanged. Repeat with MAX_WAIT=2 -> hazard_timeout=1 and stays 1.
- blez/bgtz: rs=0x80000000 blez -> taken. bgtz with rs=0 -> not taken. blez with rt_hazard=1 -> no stall. ext_op: 0x0D -> 0, 0x23 -> 1.
- Handshake back-pressure: redirect_ready=0 for 4 cycles -> redirect_valid, if_flush, redirect_pc stable for 5 cycles; a branch in ID meanwhile is ignored.
- Reset in REDIRECT and in WAIT_OPND -> next cycle all outputs 0, counters 0, state IDLE. Counter saturation: preload to 0xFFFF via 65535 taken branches -> stays 0xFFFF.
